// File: rtl/robo_seguidor_param.sv
// Wall-following robot controller: synchronised, debounced head/left sensors feeding a Moore FSM
// with left-wall gap tolerance, rotation timeout, back-up manoeuvre and pause. Optional macro: ODOMETRIA_EN.
//
// state        | meaning
// PROCURANDO   | no wall known, drive forward looking for one
// ROTACIONANDO | wall ahead, rotate in place until the left wall is found or timeout
// ACOMPANHANDO | left wall present, drive forward alongside it
// RECUANDO     | rotation timed out, back up for REC_LEN cycles
module robo_seguidor_param #(
   parameter int DEB_LEN  = 4,
   parameter int ROT_MAX  = 16,
   parameter int LOST_MAX = 8,
   parameter int REC_LEN  = 6,
   parameter int CNT_W    = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             head,
   input  logic             left,
   input  logic             pausa,
`ifdef ODOMETRIA_EN
   input  logic             zerar_passos,
   output logic [CNT_W-1:0] passos,
`endif
   output logic             avancar,
   output logic             girar,
   output logic             recuar,
   output logic [1:0]       estado
);

   typedef enum logic [1:0] {
      PROCURANDO   = 2'b00,
      ROTACIONANDO = 2'b01,
      ACOMPANHANDO = 2'b10,
      RECUANDO     = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] DEB_TC   = CNT_W'(DEB_LEN - 1);
   localparam logic [CNT_W-1:0] ROT_TC   = CNT_W'(ROT_MAX - 1);
   localparam logic [CNT_W-1:0] LOST_TC  = CNT_W'(LOST_MAX - 1);
   localparam logic [CNT_W-1:0] REC_TC   = CNT_W'(REC_LEN - 1);

   // index 1 = head, index 0 = left
   logic [1:0]       r_sync1;
   logic [1:0]       r_sync2;
   logic [1:0]       r_filt;
   logic [CNT_W-1:0] r_deb_cnt [2];

   logic             w_hf;
   logic             w_lf;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_rot_cnt;
   logic [CNT_W-1:0] r_perda_cnt;
   logic [CNT_W-1:0] r_rec_cnt;
   logic [CNT_W-1:0] w_rot_cnt;
   logic [CNT_W-1:0] w_perda_cnt;
   logic [CNT_W-1:0] w_rec_cnt;

   logic             r_avancar;
   logic             r_girar;
   logic             r_recuar;
   logic             w_avancar;
   logic             w_girar;
   logic             w_recuar;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sync1 <= 2'b00;
         r_sync2 <= 2'b00;
         r_filt  <= 2'b00;
         for (int i = 0; i < 2; i++) r_deb_cnt[i] <= '0;
      end else begin
         r_sync1 <= {head, left};
         r_sync2 <= r_sync1;
         for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] == r_filt[i]) begin
               r_deb_cnt[i] <= '0;
            end else if (r_deb_cnt[i] == DEB_TC) begin
               r_filt[i]    <= r_sync2[i];
               r_deb_cnt[i] <= '0;
            end else begin
               r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign w_hf = r_filt[1];
   assign w_lf = r_filt[0];

   always_comb begin
      w_next      = r_state;
      w_rot_cnt   = r_rot_cnt;
      w_perda_cnt = r_perda_cnt;
      w_rec_cnt   = r_rec_cnt;
      case (r_state)
         PROCURANDO: begin
            if (w_hf)      w_next = ROTACIONANDO;
            else if (w_lf) w_next = ACOMPANHANDO;
         end
         ROTACIONANDO: begin
            if (!w_hf && w_lf)            w_next = ACOMPANHANDO;
            else if (r_rot_cnt == ROT_TC) w_next = RECUANDO;
            else                          w_rot_cnt = r_rot_cnt + 1'b1;
         end
         ACOMPANHANDO: begin
            if (w_hf)                          w_next = ROTACIONANDO;
            else if (w_lf)                     w_perda_cnt = '0;
            else if (r_perda_cnt == LOST_TC)   w_next = PROCURANDO;
            else                               w_perda_cnt = r_perda_cnt + 1'b1;
         end
         RECUANDO: begin
            if (r_rec_cnt == REC_TC) w_next = ROTACIONANDO;
            else                     w_rec_cnt = r_rec_cnt + 1'b1;
         end
         default: w_next = PROCURANDO;
      endcase
      // every state change starts the entered state's counter from zero
      if (w_next != r_state) begin
         w_rot_cnt   = '0;
         w_perda_cnt = '0;
         w_rec_cnt   = '0;
      end
      w_avancar = !pausa && (w_next == PROCURANDO || w_next == ACOMPANHANDO);
      w_girar   = !pausa && (w_next == ROTACIONANDO);
      w_recuar  = !pausa && (w_next == RECUANDO);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= PROCURANDO;
         r_rot_cnt   <= '0;
         r_perda_cnt <= '0;
         r_rec_cnt   <= '0;
         r_avancar   <= 1'b0;
         r_girar     <= 1'b0;
         r_recuar    <= 1'b0;
      end else begin
         if (!pausa) begin
            r_state     <= w_next;
            r_rot_cnt   <= w_rot_cnt;
            r_perda_cnt <= w_perda_cnt;
            r_rec_cnt   <= w_rec_cnt;
         end
         r_avancar <= w_avancar;
         r_girar   <= w_girar;
         r_recuar  <= w_recuar;
      end
   end

   assign avancar = r_avancar;
   assign girar   = r_girar;
   assign recuar  = r_recuar;
   assign estado  = r_state;

`ifdef ODOMETRIA_EN
   logic [CNT_W-1:0] r_passos;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)                                       r_passos <= '0;
      else if (zerar_passos)                           r_passos <= '0;
      else if (!pausa && r_avancar && r_passos != '1)  r_passos <= r_passos + 1'b1;
   end

   assign passos = r_passos;
`endif

endmodule
